pixel_packer: RTL and testbench
===============================

# pixel_packer

Drains the 8-bit pixel stream that the edge-detection stage writes into its output FIFO, and packs consecutive pixels into wide words for the downstream word FIFO feeding the frame-buffer writer. It sits between the sobel output FIFO (read side) and the DMA word FIFO (write side). It tracks frame position so that the final word of each frame is tagged and, if partial, zero-padded and flushed.

## Interface
- DATA_WIDTH, 8, bits per pixel
- PIXELS_PER_WORD, 4, pixels packed per output word (≥1)
- IMAGE_WIDTH, 720, pixels per line
- IMAGE_HEIGHT, 540, lines per frame
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- input_empty  input  1  pixel FIFO empty flag (first-word-fall-through)
- pixel_in  input  DATA_WIDTH  head of pixel FIFO; valid when !input_empty
- read_fifo  output  1  pop strobe to pixel FIFO; combinational; pixel_in is consumed in the same cycle
- output_full  input  1  word FIFO full flag
- write_fifo  output  1  push strobe to word FIFO; combinational
- word_out  output  DATA_WIDTH*PIXELS_PER_WORD  packed word, registered
- word_last  output  1  registered; qualifies word_out as the final word of a frame
- frame_done  output  1  registered one-cycle pulse after the last word of a frame is pushed

## Operation
- Lane order: pixel k of a word occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; the first pixel received goes into the LSBs.
- Counters: lane_cnt 0..PIXELS_PER_WORD-1; pix_cnt 0..IMAGE_WIDTH*IMAGE_HEIGHT-1, wraps to 0 after the last pixel of a frame.
- FSM states: FILL, SEND. Reset state is FILL.
- FILL, with !input_empty: read_fifo=1; pixel written to lane lane_cnt.
  - Writing lane 0 clears all other lanes of the word register.
  - lane_cnt and pix_cnt increment.
  - If lane_cnt==PIXELS_PER_WORD-1 or pix_cnt is the last pixel of the frame: lane_cnt←0, word_last←(last pixel), go to SEND.
- FILL, with input_empty: hold all state.
- SEND, with output_full: write_fifo=0, read_fifo=0, hold the word.
- SEND, with !output_full: write_fifo=1.
  - If word_last was set: frame_done←1 next cycle.
  - Simultaneously, if !input_empty: read_fifo=1; the next pixel is loaded into lane 0 with the other lanes cleared, and word_last is recomputed.
  - Next state is FILL, or SEND again if that pixel completes a word (PIXELS_PER_WORD==1 or last of frame).
  - If input_empty: go to FILL, lane_cnt=0.
- Partial final word: unused upper lanes are 0; pushed with word_last=1.
- read_fifo is never asserted when input_empty; write_fifo is never asserted when output_full.

## Timing
- Reset values: read_fifo=0, write_fifo=0, word_out=0, word_last=0, frame_done=0, lane_cnt=0, pix_cnt=0, state=FILL.
- read_fifo and write_fifo are forced to 0 while rst is high.
- Latency: the pixel completing a word is popped in cycle N; write_fifo is asserted in cycle N+1 if !output_full.
- Throughput: 1 pixel/cycle sustained with no stalls; the SEND/pop overlap removes any bubble.
- frame_done is high exactly one cycle, in the cycle after the word_last push.
- Back-pressure: while output_full is held, at most one word is buffered internally and no pixels are popped.
- Reset mid-frame: any partial word is discarded and pix_cnt restarts at 0. The next pixel popped is treated as pixel 0 of a new frame.

## Structure
- Shared package pixel_pkg: packer_state_t enum {FILL, SEND}; localparam FRAME_PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT; counter width via $clog2(FRAME_PIXELS).
- Sub-module frame_pixel_counter: wrapping pix_cnt with an is_last output; reusable by other stream stages.
- Everything else is flat in pixel_packer.

## Test plan
- Continuous stream 0x01..0x08, output never full -> two pushes on consecutive-pixel cadence: 0x04030201 then 0x08070605, write_fifo pulses 4 cycles apart, no pop bubbles.
- Word completes while output_full=1 for 3 cycles -> no pops and no pushes during those cycles; word pushed the cycle output_full drops, with the next pixel popped in the same cycle.
- IMAGE_WIDTH=3, IMAGE_HEIGHT=2 (6 pixels), pixels 0xA0..0xA5 -> words 0xA3A2A1A0 (word_last=0) and 0x0000A5A4 (word_last=1); frame_done pulses once, one cycle later.
- Two back-to-back frames with the above params -> second frame's first word contains pixel 0 of frame 2 in the LSBs; pix_cnt wrap verified.
- Assert rst after 2 pixels of a word, release, send 4 pixels 0x11..0x14 -> single word 0x14131211; earlier pixels absent; all outputs 0 during reset.
- Random input_empty/output_full toggling over 10 frames against a reference model -> identical word sequence, no pop on empty, no push on full.

Source files
------------

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and frame geometry for the pixel packing stages
package pixel_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } packer_state_t;

  localparam int IMAGE_WIDTH_DEF  = 720;
  localparam int IMAGE_HEIGHT_DEF = 540;
  localparam int FRAME_PIXELS     = IMAGE_WIDTH_DEF * IMAGE_HEIGHT_DEF;

  // Counter width for a 0..n-1 range; never zero so single-value ranges stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// rtl/frame_pixel_counter.sv - wrapping per-frame pixel position with last-pixel flag
module frame_pixel_counter
  import pixel_pkg::*;
#(
  parameter int NUM_PIXELS = FRAME_PIXELS,
  parameter int CNT_W      = cnt_width(NUM_PIXELS)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic is_last
);

  logic [CNT_W-1:0] pix_cnt;

  assign is_last = (pix_cnt == CNT_W'(NUM_PIXELS - 1));

  // Advance one position per consumed pixel, wrapping after the final pixel of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (inc) begin
      pix_cnt <= is_last ? '0 : pix_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs pixel FIFO output into wide words with end-of-frame tagging
module pixel_packer
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int PIXELS_PER_WORD = 4,
  parameter int IMAGE_WIDTH     = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT    = IMAGE_HEIGHT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  input_empty,
  input  logic [DATA_WIDTH-1:0]                 pixel_in,
  output logic                                  read_fifo,
  input  logic                                  output_full,
  output logic                                  write_fifo,
  output logic [DATA_WIDTH*PIXELS_PER_WORD-1:0] word_out,
  output logic                                  word_last,
  output logic                                  frame_done
);

  localparam int WORD_W     = DATA_WIDTH * PIXELS_PER_WORD;
  localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int LANE_W     = cnt_width(PIXELS_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);

  packer_state_t     state;
  logic [LANE_W-1:0] lane_cnt;
  logic              pix_last;
  logic              word_done;
  logic [WORD_W-1:0] word_nxt;

  frame_pixel_counter #(
    .NUM_PIXELS (NUM_PIXELS)
  ) u_frame_pixel_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (read_fifo),
    .is_last (pix_last)
  );

  // Pop whenever a pixel is waiting and there is room: in FILL always, in SEND only
  // alongside the push so a completed word never costs a pop bubble.
  always_comb begin
    read_fifo  = 1'b0;
    write_fifo = 1'b0;
    if (!rst) begin
      write_fifo = (state == SEND) && !output_full;
      read_fifo  = !input_empty && ((state == FILL) || !output_full);
    end
  end

  // lane_cnt is always 0 in SEND, so the popped pixel lands in lane 0 there.
  assign word_done = (lane_cnt == LAST_LANE) || pix_last;

  // Merge the incoming pixel into its lane; starting a new word clears the stale lanes.
  always_comb begin
    word_nxt = (lane_cnt == '0) ? '0 : word_out;
    word_nxt[DATA_WIDTH*int'(lane_cnt) +: DATA_WIDTH] = pixel_in;
  end

  // Fill/send sequencing with registered word, tag and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      lane_cnt   <= '0;
      word_out   <= '0;
      word_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= write_fifo && word_last;
      if (read_fifo) begin
        word_out  <= word_nxt;
        word_last <= pix_last;
        if (word_done) begin
          lane_cnt <= '0;
          state    <= SEND;
        end else begin
          lane_cnt <= lane_cnt + LANE_W'(1);
          state    <= FILL;
        end
      end else if (write_fifo) begin
        lane_cnt  <= '0;
        word_last <= 1'b0;
        state     <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// tb/tb_pixel_packer.sv - scoreboard bench for pixel_packer on a full-size and a 3x2 frame
module tb_pixel_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_empty, a_full, a_rd, a_wr, a_last, a_fd;
  logic [7:0]  a_pix;
  logic [31:0] a_word;
  logic        b_empty, b_full, b_rd, b_wr, b_last, b_fd;
  logic [7:0]  b_pix;
  logic [31:0] b_word;

  pixel_packer #(
    .DATA_WIDTH(8), .PIXELS_PER_WORD(4), .IMAGE_WIDTH(720), .IMAGE_HEIGHT(540)
  ) dut_a (
    .clk(clk), .rst(rst), .input_empty(a_empty), .pixel_in(a_pix), .read_fifo(a_rd),
    .output_full(a_full), .write_fifo(a_wr), .word_out(a_word), .word_last(a_last),
    .frame_done(a_fd)
  );

  pixel_packer #(
    .DATA_WIDTH(8), .PIXELS_PER_WORD(4), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .input_empty(b_empty), .pixel_in(b_pix), .read_fifo(b_rd),
    .output_full(b_full), .write_fifo(b_wr), .word_out(b_word), .word_last(b_last),
    .frame_done(b_fd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic        l;
  } exp_t;

  exp_t        exp_q [2][$];
  logic [7:0]  src_q [2][$];
  int          m_lane [2];
  int          m_pos  [2];
  int          m_fp   [2];
  logic [31:0] m_word [2];
  logic        exp_fd [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel     = 0;
  int   fd_cnt  = 0;
  logic gate_empty = 1'b0;
  logic gate_full  = 1'b0;
  logic rst_req    = 1'b1;

  logic        s_rd, s_wr, s_last, s_fd, s_empty, s_full;
  logic [31:0] s_word;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference packing: words depend only on pixel order and frame position.
  task automatic put_pix(input int d, input logic [7:0] p);
    logic last;
    src_q[d].push_back(p);
    if (m_lane[d] == 0) m_word[d] = 32'h0;
    m_word[d][m_lane[d]*8 +: 8] = p;
    last = (m_pos[d] == m_fp[d] - 1);
    m_pos[d] = last ? 0 : m_pos[d] + 1;
    if (m_lane[d] == 3 || last) begin
      exp_q[d].push_back('{w: m_word[d], l: last});
      m_lane[d] = 0;
    end else begin
      m_lane[d]++;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lane[d] = 0;
      m_pos[d]  = 0;
      m_word[d] = 32'h0;
      exp_fd[d] = 1'b0;
      exp_q[d].delete();
      src_q[d].delete();
    end
  endtask

  task automatic step();
    exp_t e;
    logic el;
    @(negedge clk);
    rst     = rst_req;
    a_empty = (sel != 0) || gate_empty || (src_q[0].size() == 0);
    a_pix   = (src_q[0].size() != 0) ? src_q[0][0] : 8'h00;
    a_full  = (sel != 0) || gate_full;
    b_empty = (sel != 1) || gate_empty || (src_q[1].size() == 0);
    b_pix   = (src_q[1].size() != 0) ? src_q[1][0] : 8'h00;
    b_full  = (sel != 1) || gate_full;
    #1;
    if (sel == 0) begin
      s_rd = a_rd; s_wr = a_wr; s_word = a_word; s_last = a_last; s_fd = a_fd;
      s_empty = a_empty; s_full = a_full;
    end else begin
      s_rd = b_rd; s_wr = b_wr; s_word = b_word; s_last = b_last; s_fd = b_fd;
      s_empty = b_empty; s_full = b_full;
    end
    chk("pop_on_empty", s_rd && s_empty, 0);
    chk("push_on_full", s_wr && s_full, 0);
    chk("frame_done", s_fd, exp_fd[sel]);
    if (s_fd) fd_cnt++;
    el = 1'b0;
    if (s_wr) begin
      n_tests++;
      assert (exp_q[sel].size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_push: got word %0h expected no push", s_word);
      end
      if (exp_q[sel].size() != 0) begin
        e  = exp_q[sel].pop_front();
        el = e.l;
        chk("word_out", s_word, e.w);
        chk("word_last", s_last, e.l);
      end
    end
    exp_fd[sel]     = s_wr && el;
    exp_fd[1 - sel] = 1'b0;
    if (s_rd && src_q[sel].size() != 0) void'(src_q[sel].pop_front());
  endtask

  task automatic drain(input string tag, input int bound);
    int k;
    k = 0;
    while ((exp_q[sel].size() != 0 || src_q[sel].size() != 0) && k < bound) begin
      step();
      k++;
    end
    step();
    chk(tag, exp_q[sel].size() + src_q[sel].size(), 0);
  endtask

  initial begin
    int pops;
    int w1;
    int w2;
    int k;
    m_fp[0] = 720 * 540;
    m_fp[1] = 6;
    model_reset();

    // Reset state
    rst_req = 1'b1;
    step();
    chk("rst_read_fifo", a_rd, 0);
    chk("rst_write_fifo", a_wr, 0);
    chk("rst_word_out", a_word, 0);
    chk("rst_word_last", a_last, 0);
    chk("rst_frame_done", a_fd, 0);
    rst_req = 1'b0;
    step();

    // Continuous stream, no back-pressure
    sel = 0;
    for (int i = 1; i <= 8; i++) put_pix(0, 8'(i));
    pops = 0; w1 = -1; w2 = -1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (s_rd) pops++;
      if (s_wr) begin
        if (w1 < 0) w1 = i;
        else w2 = i;
      end
    end
    chk("t1_pop_count", pops, 8);
    chk("t1_first_push_cycle", w1, 4);
    chk("t1_push_spacing", w2 - w1, 4);
    drain("t1_drain", 50);

    // Word completes under back-pressure
    gate_full = 1'b1;
    for (int i = 0; i < 5; i++) put_pix(0, 8'(8'h21 + i));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_fill_pop", s_rd, 1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_pop", s_rd, 0);
      chk("t2_hold_push", s_wr, 0);
    end
    gate_full = 1'b0;
    step();
    chk("t2_release_push", s_wr, 1);
    chk("t2_release_pop", s_rd, 1);
    drain("t2_drain", 50);

    // Reset mid-word
    put_pix(0, 8'h30);
    step();
    chk("t5_second_pixel_pop", s_rd, 1);
    rst_req = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) put_pix(0, 8'(8'h11 + i));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5_rst_read_fifo", a_rd, 0);
      chk("t5_rst_write_fifo", a_wr, 0);
      chk("t5_rst_word_out", a_word, 0);
      chk("t5_rst_word_last", a_last, 0);
      chk("t5_rst_frame_done", a_fd, 0);
    end
    rst_req = 1'b0;
    drain("t5_drain", 50);

    // Small frame: full word then zero-padded last word
    sel = 1;
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) put_pix(1, 8'(8'hA0 + i));
    drain("t3_drain", 50);
    chk("t3_frame_done_count", fd_cnt, 1);

    // Two back-to-back frames exercise the position wrap
    fd_cnt = 0;
    for (int i = 0; i < 12; i++) put_pix(1, 8'(8'hB0 + i));
    drain("t4_drain", 80);
    chk("t4_frame_done_count", fd_cnt, 2);

    // Random empty/full gating over ten frames
    fd_cnt = 0;
    for (int i = 0; i < 60; i++) put_pix(1, 8'($urandom));
    k = 0;
    while ((exp_q[1].size() != 0 || src_q[1].size() != 0) && k < 3000) begin
      gate_empty = ($urandom_range(0, 3) == 0);
      gate_full  = ($urandom_range(0, 2) == 0);
      step();
      k++;
    end
    gate_empty = 1'b0;
    gate_full  = 1'b0;
    drain("rand_drain", 100);
    chk("rand_frame_done_count", fd_cnt, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
